addsub_serial: RTL and testbench

//  Multi-cycle, parametrised N-bit adder/subtractor. Consumes BPC bits per clock through a ripple slice,
//  LSB first, with a registered carry/borrow between cycles. Successor to the 1-bit add/sub cell:

---
 rtl/addsub_pkg.sv | 23 ++
 rtl/addsub_serial_if.sv | 28 ++
 rtl/addsub_slice.sv | 40 ++++
 rtl/addsub_serial.sv | 147 ++++++++++++++
 tb/tb_addsub_serial.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/addsub_pkg.sv
// Shared types and helpers for the serial adder/subtractor.
// Holds the FSM state encoding, operation codes and the signed-overflow rule.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_SUB = 1'b0;
  localparam logic OP_ADD = 1'b1;

  // Overflow only needs the operand and result sign bits.
  function automatic logic signedOvf(input logic opAdd, input logic aMsb,
                                     input logic bMsb, input logic rMsb);
    if (opAdd == OP_ADD) begin
      return (aMsb == bMsb) && (rMsb != aMsb);
    end
    return (aMsb != bMsb) && (rMsb != aMsb);
  endfunction

endpackage

// File: rtl/addsub_serial_if.sv
// Request/response bundle between the datapath controller and the serial add/sub unit.
// The controller side uses the master modport, the arithmetic unit the slave modport.
interface addsub_serial_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic             a_ns;
  logic             cin;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a_ns, cin, a_in, b_in,
    input  busy, done, result, cout, ovf
  );

  modport slave (
    input  start, a_ns, cin, a_in, b_in,
    output busy, done, result, cout, ovf
  );

endinterface

// File: rtl/addsub_slice.sv
// Combinational BPC-bit ripple of add/sub cells; in subtract mode the chained bit is a borrow.
// Also exposes the carry into and out of the most significant cell.
module addsub_slice
  import addsub_pkg::*;
#(
  parameter int BPC = 1
) (
  input  logic [BPC-1:0] a_i,
  input  logic [BPC-1:0] b_i,
  input  logic           a_ns_i,
  input  logic           c_i,
  output logic [BPC-1:0] s_o,
  output logic           c_o,
  output logic           msb_c_in_o,
  output logic           msb_c_out_o
);

  logic carry;

  always_comb begin
    s_o         = '0;
    msb_c_in_o  = 1'b0;
    msb_c_out_o = 1'b0;
    carry       = c_i;
    for (int i = 0; i < BPC; i++) begin
      s_o[i] = a_i[i] ^ b_i[i] ^ carry;
      if (i == BPC - 1) begin
        msb_c_in_o = carry;
      end
      if (a_ns_i == OP_ADD) begin
        carry = (a_i[i] & b_i[i]) | ((a_i[i] ^ b_i[i]) & carry);
      end else begin
        carry = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & carry);
      end
    end
    msb_c_out_o = carry;
    c_o         = carry;
  end

endmodule

// File: rtl/addsub_serial.sv
// Multi-cycle N-bit adder/subtractor: BPC bits per clock, LSB first, registered carry/borrow.
// start/done handshake through addsub_serial_if; result, cout and ovf held until the next completion.
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  addsub_serial_if.slave bus
);

  localparam int N  = WIDTH / BPC;
  localparam int CW = $clog2(N + 1);

  if ((WIDTH % BPC) != 0) begin : gBadBpc
    $error("addsub_serial: WIDTH must be a multiple of BPC");
  end
  if (WIDTH < 2) begin : gBadWidth
    $error("addsub_serial: WIDTH must be at least 2");
  end

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] aSh_q, aSh_d;
  logic [WIDTH-1:0] bSh_q, bSh_d;
  logic [WIDTH-1:0] rSh_q, rSh_d;
  logic             carry_q, carry_d;
  logic             opAdd_q, opAdd_d;
  logic             aMsb_q, aMsb_d;
  logic             bMsb_q, bMsb_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [BPC-1:0]   sliceSum;
  logic             sliceCarry;
  logic             unusedMsbCin;
  logic             unusedMsbCout;
  logic [WIDTH-1:0] rShifted;
  logic             accept;

  addsub_slice #(.BPC(BPC)) uSlice (
    .a_i         (aSh_q[BPC-1:0]),
    .b_i         (bSh_q[BPC-1:0]),
    .a_ns_i      (opAdd_q),
    .c_i         (carry_q),
    .s_o         (sliceSum),
    .c_o         (sliceCarry),
    .msb_c_in_o  (unusedMsbCin),
    .msb_c_out_o (unusedMsbCout)
  );

  if (BPC == WIDTH) begin : gFullSlice
    assign rShifted = sliceSum;
  end else begin : gPartSlice
    assign rShifted = {sliceSum, rSh_q[WIDTH-1:BPC]};
  end

  assign accept = bus.start && (state_q != RUN);

  // The counter starts at N: counts N..1 each consume one slice, and the
  // count-0 cycle hands the finished shift register over to the output registers.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    aSh_d    = aSh_q;
    bSh_d    = bSh_q;
    rSh_d    = rSh_q;
    carry_d  = carry_q;
    opAdd_d  = opAdd_q;
    aMsb_d   = aMsb_q;
    bMsb_d   = bMsb_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    case (state_q)
      RUN: begin
        if (cnt_q != '0) begin
          aSh_d   = aSh_q >> BPC;
          bSh_d   = bSh_q >> BPC;
          rSh_d   = rShifted;
          carry_d = sliceCarry;
          cnt_d   = cnt_q - CW'(1);
        end else begin
          state_d  = DONE;
          result_d = rSh_q;
          cout_d   = carry_q;
          ovf_d    = signedOvf(opAdd_q, aMsb_q, bMsb_q, rSh_q[WIDTH-1]);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d = RUN;
      cnt_d   = CW'(N);
      aSh_d   = bus.a_in;
      bSh_d   = bus.b_in;
      rSh_d   = '0;
      carry_d = bus.cin;
      opAdd_d = bus.a_ns;
      aMsb_d  = bus.a_in[WIDTH-1];
      bMsb_d  = bus.b_in[WIDTH-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      aSh_q    <= '0;
      bSh_q    <= '0;
      rSh_q    <= '0;
      carry_q  <= 1'b0;
      opAdd_q  <= OP_SUB;
      aMsb_q   <= 1'b0;
      bMsb_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      aSh_q    <= aSh_d;
      bSh_q    <= bSh_d;
      rSh_q    <= rSh_d;
      carry_q  <= carry_d;
      opAdd_q  <= opAdd_d;
      aMsb_q   <= aMsb_d;
      bMsb_q   <= bMsb_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy   = (state_q == RUN);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Self-checking bench for addsub_serial: directed cases plus random ops on two configurations
// (8-bit/1 bit per clock and 16-bit/4 bits per clock) against an integer arithmetic model.
module tb_addsub_serial;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  addsub_serial_if #(.WIDTH(8))  bus8 ();
  addsub_serial_if #(.WIDTH(16)) bus16 ();

  addsub_serial #(.WIDTH(8), .BPC(1)) dut8 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus8.slave)
  );

  addsub_serial #(.WIDTH(16), .BPC(4)) dut16 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus16.slave)
  );

  // Arithmetic reference: exact integer sum/difference, wrap, and signed range test.
  function automatic void model(input int w, input logic [15:0] a, input logic [15:0] b,
                                input logic add, input logic cin,
                                output logic [15:0] r, output logic co, output logic ov);
    longint modv = longint'(1) << w;
    longint ua   = longint'(a);
    longint ub   = longint'(b);
    longint ci   = longint'(cin);
    longint full;
    longint sa, sb, t;
    if (add) begin
      full = ua + ub + ci;
      co   = (full >= modv);
    end else begin
      full = ua - ub - ci;
      co   = (full < 0);
    end
    r  = 16'(((full % modv) + modv) % modv);
    sa = (ua >= modv / 2) ? ua - modv : ua;
    sb = (ub >= modv / 2) ? ub - modv : ub;
    t  = add ? (sa + sb + ci) : (sa - sb - ci);
    ov = (t < -(modv / 2)) || (t > (modv / 2 - 1));
  endfunction

  function automatic logic [15:0] pickOperand(input int w);
    logic [15:0] v;
    logic [15:0] msk;
    msk = (w == 16) ? 16'hFFFF : 16'h00FF;
    case ($urandom_range(0, 7))
      0:       v = 16'h0000;
      1:       v = msk;
      2:       v = msk >> 1;
      3:       v = (msk >> 1) + 16'h0001;
      default: v = 16'($urandom) & msk;
    endcase
    return v;
  endfunction

  task automatic runOp8(input logic [7:0] a, input logic [7:0] b, input logic add, input logic cin,
                        output int lat, output logic busyAfter);
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.a_in  = a;
    bus8.b_in  = b;
    bus8.a_ns  = add;
    bus8.cin   = cin;
    @(posedge clk);
    @(negedge clk);
    bus8.start = 1'b0;
    bus8.a_in  = 8'($urandom);
    bus8.b_in  = 8'($urandom);
    bus8.a_ns  = 1'($urandom);
    bus8.cin   = 1'($urandom);
    busyAfter  = bus8.busy;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus8.done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic runOp16(input logic [15:0] a, input logic [15:0] b, input logic add, input logic cin,
                         output int lat, output logic busyAfter);
    @(negedge clk);
    bus16.start = 1'b1;
    bus16.a_in  = a;
    bus16.b_in  = b;
    bus16.a_ns  = add;
    bus16.cin   = cin;
    @(posedge clk);
    @(negedge clk);
    bus16.start = 1'b0;
    bus16.a_in  = 16'($urandom);
    bus16.b_in  = 16'($urandom);
    bus16.a_ns  = 1'($urandom);
    bus16.cin   = 1'($urandom);
    busyAfter   = bus16.busy;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus16.done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus8.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy8 got=%b exp=0", bus8.busy); end
    checks++; if (bus8.done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done8 got=%b exp=0", bus8.done); end
    checks++; if (bus8.result !== 8'h00) begin failures++; $display("[TB] FAIL reset_result8 got=%h exp=00", bus8.result); end
    checks++; if (bus8.cout !== 1'b0) begin failures++; $display("[TB] FAIL reset_cout8 got=%b exp=0", bus8.cout); end
    checks++; if (bus8.ovf !== 1'b0) begin failures++; $display("[TB] FAIL reset_ovf8 got=%b exp=0", bus8.ovf); end
    checks++; if ({bus16.busy, bus16.done, bus16.cout, bus16.ovf} !== 4'b0000) begin
      failures++; $display("[TB] FAIL reset_flags16 got=%b exp=0000", {bus16.busy, bus16.done, bus16.cout, bus16.ovf});
    end
    checks++; if (bus16.result !== 16'h0000) begin failures++; $display("[TB] FAIL reset_result16 got=%h exp=0000", bus16.result); end
    rst = 1'b0;
  endtask

  task automatic test_directed8(input string name, input logic [7:0] a, input logic [7:0] b,
                                input logic add, input logic cin,
                                input logic [7:0] expR, input logic expC, input logic expV);
    int   lat;
    logic busyAfter;
    runOp8(a, b, add, cin, lat, busyAfter);
    checks++; if (busyAfter !== 1'b1) begin failures++; $display("[TB] FAIL %s_busy got=%b exp=1", name, busyAfter); end
    checks++; if (lat !== 9) begin failures++; $display("[TB] FAIL %s_latency got=%0d exp=9", name, lat); end
    checks++; if (bus8.result !== expR) begin failures++; $display("[TB] FAIL %s_result got=%h exp=%h", name, bus8.result, expR); end
    checks++; if (bus8.cout !== expC) begin failures++; $display("[TB] FAIL %s_cout got=%b exp=%b", name, bus8.cout, expC); end
    checks++; if (bus8.ovf !== expV) begin failures++; $display("[TB] FAIL %s_ovf got=%b exp=%b", name, bus8.ovf, expV); end
  endtask

  task automatic test_start_ignored();
    int lat;
    @(negedge clk);
    bus8.start = 1'b1; bus8.a_in = 8'h12; bus8.b_in = 8'h34; bus8.a_ns = 1'b1; bus8.cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus8.start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus8.done) begin
        lat = i;
        break;
      end
      if (i == 3) begin
        bus8.start = 1'b1; bus8.a_in = 8'hAA; bus8.b_in = 8'h55; bus8.a_ns = 1'b0; bus8.cin = 1'b1;
      end else begin
        bus8.start = 1'b0;
      end
    end
    checks++; if (lat !== 9) begin failures++; $display("[TB] FAIL ignored_latency got=%0d exp=9", lat); end
    checks++; if (bus8.result !== 8'h46) begin failures++; $display("[TB] FAIL ignored_result got=%h exp=46", bus8.result); end
    checks++; if ({bus8.cout, bus8.ovf} !== 2'b00) begin failures++; $display("[TB] FAIL ignored_flags got=%b exp=00", {bus8.cout, bus8.ovf}); end

    // Back-to-back: start while done is high.
    bus8.start = 1'b1; bus8.a_in = 8'h80; bus8.b_in = 8'h80; bus8.a_ns = 1'b1; bus8.cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus8.start = 1'b0;
    checks++; if ({bus8.busy, bus8.done} !== 2'b10) begin failures++; $display("[TB] FAIL b2b_busy_done got=%b exp=10", {bus8.busy, bus8.done}); end
    checks++; if (bus8.result !== 8'h46) begin failures++; $display("[TB] FAIL b2b_held_result got=%h exp=46", bus8.result); end
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus8.done) begin
        lat = i;
        break;
      end
    end
    checks++; if (lat !== 9) begin failures++; $display("[TB] FAIL b2b_latency got=%0d exp=9", lat); end
    checks++; if (bus8.result !== 8'h00) begin failures++; $display("[TB] FAIL b2b_result got=%h exp=00", bus8.result); end
    checks++; if ({bus8.cout, bus8.ovf} !== 2'b11) begin failures++; $display("[TB] FAIL b2b_flags got=%b exp=11", {bus8.cout, bus8.ovf}); end
  endtask

  task automatic test_reset_mid_run();
    logic sawDone;
    @(negedge clk);
    bus8.start = 1'b1; bus8.a_in = 8'h0F; bus8.b_in = 8'h01; bus8.a_ns = 1'b1; bus8.cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus8.start = 1'b0;
    for (int i = 1; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++; if ({bus8.busy, bus8.done, bus8.cout, bus8.ovf} !== 4'b0000) begin
      failures++; $display("[TB] FAIL midrst_flags got=%b exp=0000", {bus8.busy, bus8.done, bus8.cout, bus8.ovf});
    end
    checks++; if (bus8.result !== 8'h00) begin failures++; $display("[TB] FAIL midrst_result got=%h exp=00", bus8.result); end
    sawDone = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus8.done || bus8.busy) sawDone = 1'b1;
    end
    checks++; if (sawDone !== 1'b0) begin failures++; $display("[TB] FAIL midrst_no_done got=%b exp=0", sawDone); end
  endtask

  task automatic test_wide();
    int   lat;
    logic busyAfter;
    runOp16(16'h8000, 16'h0001, 1'b0, 1'b0, lat, busyAfter);
    checks++; if (busyAfter !== 1'b1) begin failures++; $display("[TB] FAIL wide_busy got=%b exp=1", busyAfter); end
    checks++; if (lat !== 5) begin failures++; $display("[TB] FAIL wide_latency got=%0d exp=5", lat); end
    checks++; if (bus16.result !== 16'h7FFF) begin failures++; $display("[TB] FAIL wide_result got=%h exp=7fff", bus16.result); end
    checks++; if ({bus16.cout, bus16.ovf} !== 2'b01) begin failures++; $display("[TB] FAIL wide_flags got=%b exp=01", {bus16.cout, bus16.ovf}); end
  endtask

  task automatic test_random8();
    int          lat;
    logic        busyAfter;
    logic [15:0] a, b, r;
    logic        add, cin, co, ov;
    for (int n = 0; n < 2000; n++) begin
      a = pickOperand(8); b = pickOperand(8);
      add = 1'($urandom); cin = 1'($urandom);
      model(8, a, b, add, cin, r, co, ov);
      runOp8(a[7:0], b[7:0], add, cin, lat, busyAfter);
      checks++; if (lat !== 9) begin failures++; $display("[TB] FAIL rnd8_latency op=%0d got=%0d exp=9", n, lat); end
      checks++; if ({bus8.cout, bus8.result, bus8.ovf} !== {co, r[7:0], ov}) begin
        failures++;
        $display("[TB] FAIL rnd8_op a=%h b=%h add=%b cin=%b got cout=%b res=%h ovf=%b exp cout=%b res=%h ovf=%b",
                 a[7:0], b[7:0], add, cin, bus8.cout, bus8.result, bus8.ovf, co, r[7:0], ov);
      end
    end
  endtask

  task automatic test_random16();
    int          lat;
    logic        busyAfter;
    logic [15:0] a, b, r;
    logic        add, cin, co, ov;
    for (int n = 0; n < 2000; n++) begin
      a = pickOperand(16); b = pickOperand(16);
      add = 1'($urandom); cin = 1'($urandom);
      model(16, a, b, add, cin, r, co, ov);
      runOp16(a, b, add, cin, lat, busyAfter);
      checks++; if (lat !== 5) begin failures++; $display("[TB] FAIL rnd16_latency op=%0d got=%0d exp=5", n, lat); end
      checks++; if ({bus16.cout, bus16.result, bus16.ovf} !== {co, r, ov}) begin
        failures++;
        $display("[TB] FAIL rnd16_op a=%h b=%h add=%b cin=%b got cout=%b res=%h ovf=%b exp cout=%b res=%h ovf=%b",
                 a, b, add, cin, bus16.cout, bus16.result, bus16.ovf, co, r, ov);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus8.start = 1'b0; bus8.a_ns = 1'b0; bus8.cin = 1'b0; bus8.a_in = '0; bus8.b_in = '0;
    bus16.start = 1'b0; bus16.a_ns = 1'b0; bus16.cin = 1'b0; bus16.a_in = '0; bus16.b_in = '0;
    test_reset();
    test_directed8("add_ovf",   8'h7F, 8'h01, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1);
    test_directed8("sub_borrow", 8'h05, 8'h07, 1'b0, 1'b0, 8'hFE, 1'b1, 1'b0);
    test_directed8("add_carry", 8'hFF, 8'h01, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0);
    test_reset_mid_run();
    test_start_ignored();
    test_wide();
    test_random8();
    test_random16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired before the test sequence completed");
    $fatal(1, "[TB] watchdog");
  end

endmodule
